hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
- Parametrised forwarding and hazard controller for the 5-stage MIPS pipeline, sitting beside the ID stage.
- Generates per-source bypass selects with E/M/W priority for NREAD source ports.
- Detects load-use, ID-resolved branch/jalr and HI/LO hazards; drives a single pipeline stall with a cause code.
- Tracks the multi-cycle mult/div unit with an internal busy counter and keeps a saturating stall-cycle counter.

Parameters:
- NREAD, 2: number of ID source-register ports.
- REGW, 5: register-index width.
- MD_LAT, 4: mult/div latency in cycles after issue (≥1).
- CNTW, 16: stall-cycle counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NREAD*REGW  source indices; port k is bits [k*REGW +: REGW].
- id_src_used  in  NREAD  port k is actually read.
- id_is_branch  in  1  beq/bne/jalr; compare or target is resolved in ID.
- id_md_start  in  1  mult/multu/div/divu in ID.
- id_reads_hilo  in  1  mfhi/mflo in ID.
- e_regwrite, e_memtoreg  in  1 each  EX-stage write enable and load flag.
- e_writereg  in  REGW  EX destination.
- m_regwrite, m_memtoreg  in  1 each  MEM-stage write enable and load flag.
- m_writereg  in  REGW  MEM destination.
- w_regwrite  in  1  WB write enable.
- w_writereg  in  REGW  WB destination.
- perf_clr  in  1  clears stall_cycles.
- id_fwd  out  2*NREAD  per-port select: 00 RF, 01 EX, 10 MEM, 11 WB.
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX.
- stall_cause  out  2  00 none, 01 load-use, 10 branch, 11 md.
- md_busy  out  1  mult/div in flight.
- stall_cycles  out  CNTW  saturating count of stalled cycles.

Behaviour:
- Definitions: hitX(k) = id_src_used[k] & x_regwrite & (x_writereg != 0) & (id_src[k] == x_writereg), for X in {E, M, W}. Register 0 never matches.
- id_fwd[k] is combinational. Priority: hitE → 01, else hitM → 10, else hitW → 11, else 00. It is computed even when stall=1; consumers ignore it while stalled.
- luse = id_valid & OR_k(hitE(k) & e_memtoreg).
- brh = id_valid & id_is_branch & OR_k(hitE(k) | (hitM(k) & m_memtoreg)). Branches never take an EX bypass. A load feeding a branch therefore stalls 2 cycles naturally.
- mdh = id_valid & md_busy & (id_reads_hilo | id_md_start).
- stall = luse | brh | mdh.
- stall_cause uses priority md > branch > load-use. It is 00 when stall=0.
- Multiple hazards and multiple ports are simply ORed. There is no separate double-stall signal: the stall is re-evaluated every cycle.
- md counter (width clog2(MD_LAT+1)):
  - Issue = id_valid & id_md_start & ~stall. On issue, the counter loads MD_LAT.
  - Otherwise, if nonzero, it decrements by 1.
  - md_busy = (counter != 0), registered-state-derived.
  - Issue on the cycle the counter reaches 0 is allowed, because mdh uses the current md_busy.
  - An mfhi issued in the cycle after the counter hits 0 proceeds with no stall.
- stall_cycles: increments when stall=1 and the counter is not all-ones; it saturates at 2^CNTW-1. perf_clr forces 0 and wins over a simultaneous increment.
- Reset: md counter 0, md_busy 0, stall_cycles 0. stall and stall_cause follow their inputs (with id_valid low they are 0). Reset mid-mult/div abandons it immediately, so md_busy=0 the next cycle.
- id_valid=0: stall=0 and cause=00. The md counter still counts down.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB codes.
  - CAUSE_NONE/LUSE/BRANCH/MD codes.
  - REGW default.
- One sub-module, hazard_fwd_sel, is instantiated NREAD times via generate. It holds the per-port hit logic and priority mux and returns its select and its hitE/hitM flags.
- The top level holds the stall OR-tree, md counter and perf counter.

Test Plan:
- add $3 in EX, sub reads $3 (port0): id_fwd[1:0]=01, stall=0. The same match with $0 gives id_fwd=00.
- lw $5 in EX; add uses $5 on port1: stall=1, cause=01 for 1 cycle. Next cycle (lw in MEM) gives id_fwd[3:2]=10, stall=0.
- lw $4 then beq $4,$0: stall for 2 cycles with cause=10, then id_fwd=11 (WB) and stall=0. stall_cycles increases by 2.
- add $6 in EX and beq $6: stall 1 cycle, then id_fwd=10, stall=0.
- mult issued with MD_LAT=4, followed by mflo: md_busy high 4 cycles, mflo stalled with cause=11 until md_busy=0, then released. A second mult during busy is also stalled.
- Assert rst with counter=2: md_busy=0 next cycle. Hold stall for 2^CNTW+5 cycles: stall_cycles saturates at all-ones. perf_clr asserted with stall=1 gives 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the pipeline hazard/forwarding logic: bypass selects,
// stall cause codes and the default register-index width.
package cpu_pkg;

  localparam int REGW_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_LUSE   = 2'b01,
    CAUSE_BRANCH = 2'b10,
    CAUSE_MD     = 2'b11
  } stall_cause_e;

  typedef struct packed {
    logic luse;
    logic brh;
    logic mdh;
  } hazard_flags_t;

  // mult/div outranks branch, which outranks load-use.
  function automatic stall_cause_e cause_encode(input hazard_flags_t f);
    if (f.mdh)       return CAUSE_MD;
    else if (f.brh)  return CAUSE_BRANCH;
    else if (f.luse) return CAUSE_LUSE;
    else             return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-source-port bypass select: matches one ID source index against the
// EX/MEM/WB destinations and picks the youngest producer.
module hazard_fwd_sel
  import cpu_pkg::*;
#(
  parameter int REGW = REGW_DEFAULT
) (
  input  logic [REGW-1:0] src_i,
  input  logic            used_i,
  input  logic            e_regwrite_i,
  input  logic [REGW-1:0] e_writereg_i,
  input  logic            m_regwrite_i,
  input  logic [REGW-1:0] m_writereg_i,
  input  logic            w_regwrite_i,
  input  logic [REGW-1:0] w_writereg_i,
  output logic [1:0]      fwd_o,
  output logic            hit_e_o,
  output logic            hit_m_o
);

  logic hit_w;

  // $0 is hard-wired, so a write to it is never a producer.
  assign hit_e_o = used_i & e_regwrite_i & (e_writereg_i != '0) & (src_i == e_writereg_i);
  assign hit_m_o = used_i & m_regwrite_i & (m_writereg_i != '0) & (src_i == m_writereg_i);
  assign hit_w   = used_i & w_regwrite_i & (w_writereg_i != '0) & (src_i == w_writereg_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (hit_e_o)      fwd_o = FWD_EX;
    else if (hit_m_o) fwd_o = FWD_MEM;
    else if (hit_w)   fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage forwarding and hazard controller: per-port bypass selects, a single
// stall with cause code, mult/div busy tracking and a saturating stall counter.
module hazard_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int NREAD  = 2,
  parameter int REGW   = REGW_DEFAULT,
  parameter int MD_LAT = 4,
  parameter int CNTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [NREAD*REGW-1:0] id_src,
  input  logic [NREAD-1:0]      id_src_used,
  input  logic                  id_is_branch,
  input  logic                  id_md_start,
  input  logic                  id_reads_hilo,
  input  logic                  e_regwrite,
  input  logic                  e_memtoreg,
  input  logic [REGW-1:0]       e_writereg,
  input  logic                  m_regwrite,
  input  logic                  m_memtoreg,
  input  logic [REGW-1:0]       m_writereg,
  input  logic                  w_regwrite,
  input  logic [REGW-1:0]       w_writereg,
  input  logic                  perf_clr,
  output logic [2*NREAD-1:0]    id_fwd,
  output logic                  stall,
  output logic [1:0]            stall_cause,
  output logic                  md_busy,
  output logic [CNTW-1:0]       stall_cycles
);

  localparam int             MDW     = $clog2(MD_LAT + 1);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LAT);

  logic [NREAD-1:0] hit_e;
  logic [NREAD-1:0] hit_m;
  hazard_flags_t    haz;
  logic             md_issue;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    hazard_fwd_sel #(
      .REGW(REGW)
    ) u_sel (
      .src_i        (id_src[k*REGW +: REGW]),
      .used_i       (id_src_used[k]),
      .e_regwrite_i (e_regwrite),
      .e_writereg_i (e_writereg),
      .m_regwrite_i (m_regwrite),
      .m_writereg_i (m_writereg),
      .w_regwrite_i (w_regwrite),
      .w_writereg_i (w_writereg),
      .fwd_o        (id_fwd[2*k +: 2]),
      .hit_e_o      (hit_e[k]),
      .hit_m_o      (hit_m[k])
    );
  end

  // Branches compare in ID, so any EX producer or a load still in MEM stalls.
  assign haz.luse = id_valid & e_memtoreg & (|hit_e);
  assign haz.brh  = id_valid & id_is_branch & ((|hit_e) | (m_memtoreg & (|hit_m)));
  assign haz.mdh  = id_valid & md_busy & (id_reads_hilo | id_md_start);

  assign stall       = haz.luse | haz.brh | haz.mdh;
  assign stall_cause = cause_encode(haz);

  // busy comes from the registered count, so an issue can land on the cycle it hits 0.
  assign md_busy  = (md_cnt_q != '0);
  assign md_issue = id_valid & id_md_start & ~stall;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue)              md_cnt_d = MD_LOAD;
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - MDW'(1);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr)                          stall_cnt_d = '0;
    else if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule
